// File: rtl/class_hvec_assoc_search.sv
// Associative search over a class-hypervector ROM: buffers a multi-frame query, scans every
// class frame by frame accumulating Hamming distance, and reports the nearest class.
module class_hvec_assoc_search #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2,
  parameter int DIST_W             = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          qry_valid,
  output logic                          qry_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] qry_frame,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [CLASS_ID_W-1:0]         res_class,
  output logic [DIST_W-1:0]             res_dist,
  output logic                          busy
);

  typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_DONE} state_t;

  localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);

  state_t                        state_q, state_d;
  logic [FRAME_IDX_W-1:0]        load_cnt_q, load_cnt_d;
  logic [CLASS_ID_W-1:0]         cls_q, cls_d;
  logic [FRAME_IDX_W-1:0]        frm_q, frm_d;
  logic [DI_PARALLEL_W_BITS-1:0] qbuf_q [NUM_FRAMES];
  logic [DI_PARALLEL_W_BITS-1:0] qbuf_d [NUM_FRAMES];
  logic [DIST_W-1:0]             acc_q, acc_d;
  logic [DIST_W-1:0]             best_dist_q, best_dist_d;
  logic [CLASS_ID_W-1:0]         best_cls_q, best_cls_d;
  logic                          res_valid_q, res_valid_d;
  logic [CLASS_ID_W-1:0]         res_class_q, res_class_d;
  logic [DIST_W-1:0]             res_dist_q, res_dist_d;
  logic                          busy_q, busy_d;

  logic [DI_PARALLEL_W_BITS-1:0] diff;
  logic [DIST_W-1:0]             pop;
  logic [DIST_W-1:0]             cand;
  logic [DIST_W-1:0]             nb_dist;
  logic [CLASS_ID_W-1:0]         nb_cls;

  // The counters double as the ROM address, so ROM data lines up with qbuf[frm] each cycle.
  always_comb begin
    diff = qbuf_q[frm_q] ^ class_vec_in;
    pop  = '0;
    for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
      pop = pop + DIST_W'(diff[i]);
    end
    cand = acc_q + pop;
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    cls_d       = cls_q;
    frm_d       = frm_q;
    qbuf_d      = qbuf_q;
    acc_d       = acc_q;
    best_dist_d = best_dist_q;
    best_cls_d  = best_cls_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_dist_d  = res_dist_q;
    busy_d      = busy_q;
    nb_dist     = best_dist_q;
    nb_cls      = best_cls_q;

    case (state_q)
      S_LOAD: begin
        if (qry_valid) begin
          qbuf_d[load_cnt_q] = qry_frame;
          if (load_cnt_q == LAST_FRM) begin
            load_cnt_d = '0;
            cls_d      = '0;
            frm_d      = '0;
            acc_d      = '0;
            busy_d     = 1'b1;
            state_d    = S_SEARCH;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      S_SEARCH: begin
        if (frm_q != LAST_FRM) begin
          acc_d = cand;
          frm_d = frm_q + 1'b1;
        end else begin
          // Strict less-than keeps the lower class index on ties.
          if (cls_q == '0 || cand < best_dist_q) begin
            nb_dist = cand;
            nb_cls  = cls_q;
          end
          best_dist_d = nb_dist;
          best_cls_d  = nb_cls;
          acc_d       = '0;
          frm_d       = '0;
          if (cls_q == LAST_CLS) begin
            cls_d       = '0;
            res_class_d = nb_cls;
            res_dist_d  = nb_dist;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            cls_d = cls_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      cls_q       <= '0;
      frm_q       <= '0;
      for (int i = 0; i < NUM_FRAMES; i++) qbuf_q[i] <= '0;
      acc_q       <= '0;
      best_dist_q <= '0;
      best_cls_q  <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_dist_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      cls_q       <= cls_d;
      frm_q       <= frm_d;
      qbuf_q      <= qbuf_d;
      acc_q       <= acc_d;
      best_dist_q <= best_dist_d;
      best_cls_q  <= best_cls_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_dist_q  <= res_dist_d;
      busy_q      <= busy_d;
    end
  end

  assign qry_ready   = (state_q == S_LOAD);
  assign frame_id    = cls_q;
  assign frame_index = frm_q;
  assign res_valid   = res_valid_q;
  assign res_class   = res_class_q;
  assign res_dist    = res_dist_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_class_hvec_assoc_search.sv
// Randomized self-checking bench for class_hvec_assoc_search with a stub ROM array and a
// brute-force nearest-class reference model.
module tb_class_hvec_assoc_search;

  localparam int W  = 64;
  localparam int NC = 8;
  localparam int NF = 3;
  localparam int LAT = NC * NF;

  logic          clk = 1'b0;
  logic          rst;
  logic          qry_valid;
  logic          qry_ready;
  logic [W-1:0]  qry_frame;
  logic [2:0]    frame_id;
  logic [1:0]    frame_index;
  logic [W-1:0]  class_vec_in;
  logic          res_valid;
  logic          res_ready;
  logic [2:0]    res_class;
  logic [7:0]    res_dist;
  logic          busy;

  logic [W-1:0]  rom [NC][NF];
  logic [W-1:0]  qry [NF];

  int check_cnt = 0;
  int pass_cnt  = 0;

  class_hvec_assoc_search dut (
    .clk(clk), .rst(rst),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_frame(qry_frame),
    .frame_id(frame_id), .frame_index(frame_index), .class_vec_in(class_vec_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_dist(res_dist), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    class_vec_in = '0;
    if (int'(frame_index) < NF) class_vec_in = rom[frame_id][frame_index];
  end

  // Reference: nearest class by total Hamming distance, lowest index on ties.
  task automatic ref_search(output int bc, output int bd);
    bd = 1 << 30;
    bc = 0;
    for (int c = 0; c < NC; c++) begin
      int d = 0;
      for (int f = 0; f < NF; f++) d += $countones(qry[f] ^ rom[c][f]);
      if (d < bd) begin
        bd = d;
        bc = c;
      end
    end
  endtask

  task automatic fill_rom_random();
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) rom[c][f] = {$urandom, $urandom};
  endtask

  task automatic load_query(input bit gapped);
    for (int f = 0; f < NF; f++) begin
      if (gapped) begin
        qry_valid = 1'b0;
        qry_frame = {$urandom, $urandom};
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      qry_valid = 1'b1;
      qry_frame = qry[f];
      @(posedge clk); #1;
    end
    qry_valid = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (res_valid !== 1'b1 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; qry_valid = 1'b0; res_ready = 1'b0; qry_frame = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++; if (qry_ready !== 1'b1) $display("[TB] FAIL reset_qry_ready: got %b expected 1", qry_ready); else pass_cnt++;
    check_cnt++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); else pass_cnt++;
    check_cnt++; if (res_class !== 3'd0) $display("[TB] FAIL reset_res_class: got %0d expected 0", res_class); else pass_cnt++;
    check_cnt++; if (res_dist !== 8'd0) $display("[TB] FAIL reset_res_dist: got %0d expected 0", res_dist); else pass_cnt++;
    check_cnt++; if (frame_id !== 3'd0) $display("[TB] FAIL reset_frame_id: got %0d expected 0", frame_id); else pass_cnt++;
    check_cnt++; if (frame_index !== 2'd0) $display("[TB] FAIL reset_frame_index: got %0d expected 0", frame_index); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_class();
    int ec, ed, cyc;
    fill_rom_random();
    for (int f = 0; f < NF; f++) qry[f] = rom[3][f];
    ref_search(ec, ed);
    load_query(1'b0);
    check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL exact_busy: got %b expected 1", busy); else pass_cnt++;
    check_cnt++; if (qry_ready !== 1'b0) $display("[TB] FAIL exact_qry_ready: got %b expected 0", qry_ready); else pass_cnt++;
    wait_result(cyc);
    check_cnt++; if (cyc != LAT) $display("[TB] FAIL exact_latency: got %0d expected %0d", cyc, LAT); else pass_cnt++;
    check_cnt++; if (res_class !== 3'(ec)) $display("[TB] FAIL exact_class: got %0d expected %0d", res_class, ec); else pass_cnt++;
    check_cnt++; if (res_dist !== 8'(ed)) $display("[TB] FAIL exact_dist: got %0d expected %0d", res_dist, ed); else pass_cnt++;
    release_result();
  endtask

  task automatic test_single_zero_class();
    int ec, ed, cyc;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) rom[c][f] = (c == 6) ? '0 : '1;
    for (int f = 0; f < NF; f++) qry[f] = '0;
    ref_search(ec, ed);
    load_query(1'b0);
    wait_result(cyc);
    check_cnt++; if (cyc != LAT) $display("[TB] FAIL zero_latency: got %0d expected %0d", cyc, LAT); else pass_cnt++;
    check_cnt++; if (res_class !== 3'(ec)) $display("[TB] FAIL zero_class: got %0d expected %0d", res_class, ec); else pass_cnt++;
    check_cnt++; if (res_dist !== 8'(ed)) $display("[TB] FAIL zero_dist: got %0d expected %0d", res_dist, ed); else pass_cnt++;
    release_result();
  endtask

  task automatic test_all_tie_max();
    int ec, ed, cyc;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) rom[c][f] = '0;
    for (int f = 0; f < NF; f++) qry[f] = '1;
    ref_search(ec, ed);
    load_query(1'b0);
    wait_result(cyc);
    check_cnt++; if (cyc != LAT) $display("[TB] FAIL tie_latency: got %0d expected %0d", cyc, LAT); else pass_cnt++;
    check_cnt++; if (res_class !== 3'(ec)) $display("[TB] FAIL tie_class: got %0d expected %0d", res_class, ec); else pass_cnt++;
    check_cnt++; if (res_dist !== 8'(ed)) $display("[TB] FAIL tie_dist: got %0d expected %0d", res_dist, ed); else pass_cnt++;
    release_result();
  endtask

  task automatic test_two_matches();
    int ec, ed, cyc;
    fill_rom_random();
    for (int f = 0; f < NF; f++) begin
      qry[f]    = {$urandom, $urandom};
      rom[2][f] = qry[f];
      rom[5][f] = qry[f];
    end
    ref_search(ec, ed);
    load_query(1'b0);
    wait_result(cyc);
    check_cnt++; if (res_class !== 3'(ec)) $display("[TB] FAIL two_match_class: got %0d expected %0d", res_class, ec); else pass_cnt++;
    check_cnt++; if (res_dist !== 8'(ed)) $display("[TB] FAIL two_match_dist: got %0d expected %0d", res_dist, ed); else pass_cnt++;
    release_result();
  endtask

  task automatic test_random_queries();
    int ec, ed, cyc, tgt;
    for (int it = 0; it < 5; it++) begin
      fill_rom_random();
      tgt = $urandom_range(0, NC - 1);
      for (int f = 0; f < NF; f++) begin
        qry[f] = rom[tgt][f];
        repeat ($urandom_range(0, 6)) qry[f][$urandom_range(0, W - 1)] ^= 1'b1;
      end
      if (it == 4) for (int f = 0; f < NF; f++) qry[f] = {$urandom, $urandom};
      ref_search(ec, ed);
      load_query(it[0]);
      wait_result(cyc);
      check_cnt++; if (cyc != LAT) $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", it, cyc, LAT); else pass_cnt++;
      check_cnt++; if (res_class !== 3'(ec)) $display("[TB] FAIL rand_class[%0d]: got %0d expected %0d", it, res_class, ec); else pass_cnt++;
      check_cnt++; if (res_dist !== 8'(ed)) $display("[TB] FAIL rand_dist[%0d]: got %0d expected %0d", it, res_dist, ed); else pass_cnt++;
      release_result();
    end
  endtask

  task automatic test_done_hold();
    int ec, ed, cyc;
    fill_rom_random();
    for (int f = 0; f < NF; f++) qry[f] = {$urandom, $urandom};
    ref_search(ec, ed);
    load_query(1'b0);
    wait_result(cyc);
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      qry_valid = 1'b1;
      qry_frame = {$urandom, $urandom};
      @(posedge clk); #1;
      check_cnt++; if (res_valid !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, res_valid); else pass_cnt++;
      check_cnt++; if (res_class !== 3'(ec) || res_dist !== 8'(ed))
        $display("[TB] FAIL hold_result[%0d]: got %0d/%0d expected %0d/%0d", i, res_class, res_dist, ec, ed);
      else pass_cnt++;
      check_cnt++; if (qry_ready !== 1'b0) $display("[TB] FAIL hold_qry_ready[%0d]: got %b expected 0", i, qry_ready); else pass_cnt++;
    end
    qry_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_cnt++; if (res_valid !== 1'b0) $display("[TB] FAIL release_valid: got %b expected 0", res_valid); else pass_cnt++;
    check_cnt++; if (qry_ready !== 1'b1) $display("[TB] FAIL release_qry_ready: got %b expected 1", qry_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL release_busy: got %b expected 0", busy); else pass_cnt++;
    // A frame wrongly taken during DONE would misalign this next query.
    for (int f = 0; f < NF; f++) qry[f] = rom[1][f];
    ref_search(ec, ed);
    load_query(1'b0);
    wait_result(cyc);
    check_cnt++; if (res_class !== 3'(ec) || res_dist !== 8'(ed))
      $display("[TB] FAIL after_hold_result: got %0d/%0d expected %0d/%0d", res_class, res_dist, ec, ed);
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_reset_mid_search();
    int ec, ed, cyc;
    fill_rom_random();
    for (int f = 0; f < NF; f++) qry[f] = {$urandom, $urandom};
    load_query(1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_cnt++; if (qry_ready !== 1'b1) $display("[TB] FAIL midrst_qry_ready: got %b expected 1", qry_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (res_valid !== 1'b0) $display("[TB] FAIL midrst_res_valid: got %b expected 0", res_valid); else pass_cnt++;
    check_cnt++; if (frame_id !== 3'd0 || frame_index !== 2'd0)
      $display("[TB] FAIL midrst_addr: got %0d/%0d expected 0/0", frame_id, frame_index);
    else pass_cnt++;
    check_cnt++; if (res_class !== 3'd0 || res_dist !== 8'd0)
      $display("[TB] FAIL midrst_result: got %0d/%0d expected 0/0", res_class, res_dist);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_rom_random();
    for (int f = 0; f < NF; f++) qry[f] = rom[4][f] ^ {32'h0, 32'h0000_0101};
    ref_search(ec, ed);
    load_query(1'b1);
    wait_result(cyc);
    check_cnt++; if (cyc != LAT) $display("[TB] FAIL midrst_latency: got %0d expected %0d", cyc, LAT); else pass_cnt++;
    check_cnt++; if (res_class !== 3'(ec)) $display("[TB] FAIL midrst_class: got %0d expected %0d", res_class, ec); else pass_cnt++;
    check_cnt++; if (res_dist !== 8'(ed)) $display("[TB] FAIL midrst_dist: got %0d expected %0d", res_dist, ed); else pass_cnt++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_exact_class();
    test_single_zero_class();
    test_all_tie_max();
    test_two_matches();
    test_random_queries();
    test_done_hold();
    test_reset_mid_search();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
